data_sram_responder: RTL and testbench

- Synchronous responder for the core's data-SRAM initiator port (en / wen / addr / wdata / rdata).
- Serves word-addressed RAM with byte-lane writes and a fixed one-cycle read latency.
- Decodes a small memory-mapped config-register window: LED register and free-running timer.
- Sits beside the CPU core in the SoC top, replacing the vendor block RAM in simulation and small FPGA builds.

---
 rtl/data_sram_responder_pkg.sv | 33 +++
 rtl/data_sram_responder_ram.sv | 50 +++++
 rtl/data_sram_responder.sv | 137 +++++++++++++
 tb/tb_data_sram_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared constants and helpers for the data-SRAM responder:
//   - config window base and register offsets
//   - read-select encoding for the registered output mux
//   - byte-lane merge helper used by every byte-writable register
// ----------------------------------------------------------------------------
package data_sram_responder_pkg;

    localparam logic [31:0] CONF_BASE = 32'hBFAF_0000;
    localparam logic [15:0] LED_OFF   = 16'hF000;
    localparam logic [15:0] TIMER_OFF = 16'hE000;

    typedef enum logic [1:0] {
        RD_RAM   = 2'd0,
        RD_LED   = 2'd1,
        RD_TIMER = 2'd2,
        RD_ZERO  = 2'd3
    } rd_sel_e;

    // Lanes with wen[i]=1 take new_word, the rest keep old_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_ram.sv
// ----------------------------------------------------------------------------
// data_sram_ram
// Word-addressed RAM, 2^AW x 32, byte write enables, synchronous read.
// Behavioural model, interchangeable with the vendor block-RAM macro.
// Ports:
//   clk, rst_n  clock / async active-low reset (output register only)
//   en          access strobe
//   wen[3:0]    byte write enables, 0 = read
//   addr        word index
//   wdata       write data
//   rdata       read data, updated one edge after a read, held otherwise
// ----------------------------------------------------------------------------
module data_sram_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && (wen == 4'b0000)) rdata_d = mem_q[addr];
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// ----------------------------------------------------------------------------
// data_sram_responder
// Responder for the core's data-SRAM port: backing RAM plus a small
// memory-mapped config window (LED register, optional free-running timer).
// Read latency is one cycle; rdata holds on idle cycles and writes.
// Build option: define CONFREG_TIMER_EN to include the timer register;
// without it the timer offset reads 0 and ignores writes.
// Ports:
//   clk, rst              clock / async active-low reset
//   data_sram_en          access request
//   data_sram_wen[3:0]    byte write enables, 0 = read
//   data_sram_addr[31:0]  byte address
//   data_sram_wdata[31:0] write data
//   data_sram_rdata[31:0] read data (cycle after read)
//   led[15:0]             LED register bits [15:0]
// ----------------------------------------------------------------------------
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    logic        conf_hit;
    logic        is_rd;
    logic        is_wr;
    rd_sel_e     sel;
    logic [31:0] ram_rdata;

    rd_sel_e     rd_sel_q,    rd_sel_d;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    logic [31:0] led_q,       led_d;
    logic [31:0] timer_val;

    assign conf_hit = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign is_rd    = data_sram_en && (data_sram_wen == 4'b0000);
    assign is_wr    = data_sram_en && (data_sram_wen != 4'b0000);

    always_comb begin
        sel = RD_RAM;
        if (conf_hit) begin
            if (data_sram_addr[15:0] == LED_OFF) begin
                sel = RD_LED;
            end else if (data_sram_addr[15:0] == TIMER_OFF) begin
`ifdef CONFREG_TIMER_EN
                sel = RD_TIMER;
`else
                sel = RD_ZERO;
`endif
            end else begin
                sel = RD_ZERO;
            end
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic [31:0] timer_inc;

    // A write lands on top of the incremented value so unwritten lanes
    // keep counting.
    always_comb begin
        timer_inc = timer_q + 32'd1;
        timer_d   = timer_inc;
        if (is_wr && (sel == RD_TIMER)) begin
            timer_d = byte_merge(timer_inc, data_sram_wdata, data_sram_wen);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_d;
    end

    assign timer_val = timer_q;
`else
    assign timer_val = '0;
`endif

    always_comb begin
        led_d = led_q;
        if (is_wr && (sel == RD_LED)) begin
            led_d = byte_merge(led_q, data_sram_wdata, data_sram_wen);
        end
    end

    // Register reads sample pre-edge values; RAM reads are owned by the RAM
    // output register so the array stays a plain sync-read block.
    always_comb begin
        reg_rdata_d = reg_rdata_q;
        rd_sel_d    = rd_sel_q;
        if (is_rd) begin
            rd_sel_d = sel;
            case (sel)
                RD_LED:   reg_rdata_d = led_q;
                RD_TIMER: reg_rdata_d = timer_val;
                default:  reg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q       <= '0;
            reg_rdata_q <= '0;
            rd_sel_q    <= RD_RAM;
        end else begin
            led_q       <= led_d;
            reg_rdata_q <= reg_rdata_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    data_sram_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst),
        .en    (data_sram_en && !conf_hit),
        .wen   (data_sram_wen),
        .addr  (data_sram_addr[MEM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    assign data_sram_rdata = (rd_sel_q == RD_RAM) ? ram_rdata : reg_rdata_q;
    assign led             = led_q[15:0];

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A_LED   = 32'hBFAF_F000;
    localparam logic [31:0] A_TIMER = 32'hBFAF_E000;
    localparam logic [31:0] A_HOLE  = 32'hBFAF_F004;

    data_sram_responder #(.MEM_AW(14)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Present one access, clock it in, return #1 after the edge.
    task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        access(1'b1, w, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        access(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_led", {16'h0, led}, 32'h0);
        rst = 1'b1;

        // First edge after release: timer is still 0 before that edge.
        rd(A_TIMER);
        check_val("timer_at_release", rdata, 32'h0);

        wr(32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
        rd(32'h0000_0100);
        check_val("ram_word", rdata, 32'hDEAD_BEEF);

        wr(32'h0000_0100, 4'b0101, 32'h1122_3344);
        rd(32'h0000_0100);
        check_val("ram_lanes", rdata, 32'hDE22_BE44);

        wr(A_LED, 4'hF, 32'h0000_A5A5);
        check_val("led_after_wr", {16'h0, led}, 32'h0000_A5A5);
        rd(A_LED);
        check_val("led_readback", rdata, 32'h0000_A5A5);

        wr(A_HOLE, 4'hF, 32'hFFFF_FFFF);
        check_val("led_hole_wr", {16'h0, led}, 32'h0000_A5A5);
        rd(A_HOLE);
        check_val("hole_read", rdata, 32'h0);

        wr(A_LED, 4'b0010, 32'h0000_3C00);
        check_val("led_lane1", {16'h0, led}, 32'h0000_3CA5);

        rd(A_LED);
        check_val("led_read2", rdata, 32'h0000_3CA5);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_val("hold_idle", rdata, 32'h0000_3CA5);
        end
        wr(32'h0000_0200, 4'hF, 32'h1234_5678);
        check_val("hold_on_write", rdata, 32'h0000_3CA5);

        wr(32'h0001_0100, 4'hF, 32'hCAFE_F00D);
        rd(32'h0000_0100);
        check_val("alias", rdata, 32'hCAFE_F00D);
        rd(32'h0000_0200);
        check_val("ram_b2b", rdata, 32'h1234_5678);

        // Write then immediate read of same word.
        wr(32'h0000_0300, 4'hF, 32'hA1B2_C3D4);
        rd(32'h0000_0300);
        check_val("wr_then_rd", rdata, 32'hA1B2_C3D4);

`ifdef CONFREG_TIMER_EN
        wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
        rd(A_TIMER);
        check_val("timer_fffe", rdata, 32'hFFFF_FFFE);
        rd(A_TIMER);
        check_val("timer_ffff", rdata, 32'hFFFF_FFFF);
        rd(A_TIMER);
        check_val("timer_wrap", rdata, 32'h0000_0000);
        rd(A_TIMER);
        check_val("timer_after_wrap", rdata, 32'h0000_0001);

        // Timer is 0x1FF at the collision edge; unwritten lanes take 0x200.
        wr(A_TIMER, 4'hF, 32'h0000_01FE);
        idle();
        wr(A_TIMER, 4'b0001, 32'h0000_0000);
        rd(A_TIMER);
        check_val("timer_collision", rdata, 32'h0000_0200);
`else
        wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
        rd(A_TIMER);
        check_val("timer_absent", rdata, 32'h0);
        idle();
        rd(A_TIMER);
        check_val("timer_absent2", rdata, 32'h0);
`endif

        // Reset in the middle of a pending read.
        rd(32'h0000_0100);
        check_val("pre_reset_rd", rdata, 32'hCAFE_F00D);
        en = 1'b1; wen = 4'h0; addr = 32'h0000_0100;
        #3;
        rst = 1'b0;
        #1;
        check_val("midrst_rdata", rdata, 32'h0);
        check_val("midrst_led", {16'h0, led}, 32'h0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd(32'h0000_0100);
        check_val("ram_kept", rdata, 32'hCAFE_F00D);
        rd(A_LED);
        check_val("led_reset_rd", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
